// File: rtl/round_timer_pkg.sv
// Shared definitions for the round timer controller.
//   state_e     : controller state encoding
//   DEF_*       : default values for the controller parameters
//   TIME_W etc. : widths of the bar-timer value, round counter and life counter
package round_timer_pkg;

  localparam int TIME_W  = 4;
  localparam int ROUND_W = 4;
  localparam int LIVES_W = 3;

  localparam int DEF_INIT_TIME  = 9;
  localparam int DEF_MIN_TIME   = 2;
  localparam int DEF_MAX_ROUNDS = 10;
  localparam int DEF_LIVES      = 3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_RUN       = 3'd2,
    S_PAUSED    = 3'd3,
    S_GAME_OVER = 3'd4
  } state_e;

endpackage

// File: rtl/round_time_step.sv
// Difficulty step for the round timer: the next round's bar-timer start
// value is one less than the current one, but never below MIN_TIME.
// A current value already at or below the floor maps to the floor.
//   cur_time_i  : current start value
//   next_time_o : start value for the following round
module round_time_step
  import round_timer_pkg::*;
#(
  parameter int MIN_TIME = DEF_MIN_TIME
) (
  input  logic [TIME_W-1:0] cur_time_i,
  output logic [TIME_W-1:0] next_time_o
);

  localparam logic [TIME_W-1:0] MinTime = TIME_W'(MIN_TIME);

  assign next_time_o = (cur_time_i > MinTime) ? (cur_time_i - TIME_W'(1)) : MinTime;

endmodule

// File: rtl/round_timer_ctrl.sv
// Round/lives sequencer for the asteroid game. Drives the LED bar timer
// (start value, enable, reload), counts rounds survived and lives left,
// and reports win/loss. All outputs are registered.
//
// Optional feature: define ROUND_TIMER_PAUSE_EN to enable the pause input
// (RUN <-> PAUSED). Without it, pause is ignored and PAUSED is never built.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin/restart pulse (IDLE, GAME_OVER only)
//   pause             : level, hold round (only with ROUND_TIMER_PAUSE_EN)
//   hit, timeout      : player struck / bar timer expired (RUN only)
//   startTime         : value loaded into the bar timer
//   timerEnable       : bar timer counting
//   timerRst          : bar timer reload
//   roundNum          : rounds survived
//   livesLeft         : remaining lives
//   roundDone         : one-cycle pulse per survived round
//   gameOver, gameWon : end-of-game flags
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | after reset, timer held in reload, wait for start
// LOAD      | one cycle, reload bar timer with current start value
// RUN       | bar timer counting, watch hit / timeout
// PAUSED    | timer frozen, all game state held
// GAME_OVER | final result shown, wait for start
module round_timer_ctrl
  import round_timer_pkg::*;
#(
  parameter int INIT_TIME  = DEF_INIT_TIME,
  parameter int MIN_TIME   = DEF_MIN_TIME,
  parameter int MAX_ROUNDS = DEF_MAX_ROUNDS,
  parameter int LIVES      = DEF_LIVES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               hit,
  input  logic               timeout,
  output logic [TIME_W-1:0]  startTime,
  output logic               timerEnable,
  output logic               timerRst,
  output logic [ROUND_W-1:0] roundNum,
  output logic [LIVES_W-1:0] livesLeft,
  output logic               roundDone,
  output logic               gameOver,
  output logic               gameWon
);

  localparam logic [TIME_W-1:0]  InitTime  = TIME_W'(INIT_TIME);
  localparam logic [ROUND_W-1:0] MaxRounds = ROUND_W'(MAX_ROUNDS);
  localparam logic [LIVES_W-1:0] InitLives = LIVES_W'(LIVES);

  state_e               state_q, state_d;
  logic [TIME_W-1:0]    cur_time_q, cur_time_d, cur_time_step;
  logic [TIME_W-1:0]    start_time_q, start_time_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic                 timer_en_q, timer_en_d;
  logic                 timer_rst_q, timer_rst_d;
  logic                 round_done_q, round_done_d;
  logic                 game_over_q, game_over_d;
  logic                 game_won_q, game_won_d;
  logic                 pause_req;

`ifdef ROUND_TIMER_PAUSE_EN
  assign pause_req = pause;
`else
  logic unused_pause;
  assign pause_req    = 1'b0;
  assign unused_pause = pause;
`endif

  round_time_step #(
    .MIN_TIME (MIN_TIME)
  ) u_step (
    .cur_time_i  (cur_time_q),
    .next_time_o (cur_time_step)
  );

  always_comb begin
    state_d      = state_q;
    cur_time_d   = cur_time_q;
    round_d      = round_q;
    lives_d      = lives_q;
    game_won_d   = game_won_q;
    round_done_d = 1'b0;

    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (start) begin
          state_d    = S_LOAD;
          cur_time_d = InitTime;
          round_d    = '0;
          lives_d    = InitLives;
          game_won_d = 1'b0;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (pause_req) begin
          state_d = S_PAUSED;
        end else if (hit) begin
          // A hit outranks a same-cycle timeout: the round restarts, not advances.
          lives_d = lives_q - LIVES_W'(1);
          if (lives_d == '0) begin
            state_d    = S_GAME_OVER;
            game_won_d = 1'b0;
          end else begin
            state_d = S_LOAD;
          end
        end else if (timeout) begin
          round_done_d = 1'b1;
          round_d      = round_q + ROUND_W'(1);
          if (round_d == MaxRounds) begin
            state_d    = S_GAME_OVER;
            game_won_d = 1'b1;
          end else begin
            cur_time_d = cur_time_step;
            state_d    = S_LOAD;
          end
        end
      end
`ifdef ROUND_TIMER_PAUSE_EN
      S_PAUSED: begin
        if (!pause) state_d = S_RUN;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with the
    // state register rather than lagging it by a cycle.
    timer_en_d   = (state_d == S_RUN);
    timer_rst_d  = (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_GAME_OVER);
    game_over_d  = (state_d == S_GAME_OVER);
    start_time_d = (state_d == S_LOAD) ? cur_time_d : start_time_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_time_q   <= InitTime;
      start_time_q <= InitTime;
      round_q      <= '0;
      lives_q      <= InitLives;
      timer_en_q   <= 1'b0;
      timer_rst_q  <= 1'b1;
      round_done_q <= 1'b0;
      game_over_q  <= 1'b0;
      game_won_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_time_q   <= cur_time_d;
      start_time_q <= start_time_d;
      round_q      <= round_d;
      lives_q      <= lives_d;
      timer_en_q   <= timer_en_d;
      timer_rst_q  <= timer_rst_d;
      round_done_q <= round_done_d;
      game_over_q  <= game_over_d;
      game_won_q   <= game_won_d;
    end
  end

  assign startTime   = start_time_q;
  assign timerEnable = timer_en_q;
  assign timerRst    = timer_rst_q;
  assign roundNum    = round_q;
  assign livesLeft   = lives_q;
  assign roundDone   = round_done_q;
  assign gameOver    = game_over_q;
  assign gameWon     = game_won_q;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed bench for round_timer_ctrl with default parameters
// (INIT_TIME=9, MIN_TIME=2, MAX_ROUNDS=10, LIVES=3).
// Observed vector layout:
//   {startTime[4], timerEnable, timerRst, roundNum[4], livesLeft[3], roundDone, gameOver, gameWon}
module tb_round_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       hit = 1'b0;
  logic       timeout = 1'b0;
  logic [3:0] startTime;
  logic       timerEnable;
  logic       timerRst;
  logic [3:0] roundNum;
  logic [2:0] livesLeft;
  logic       roundDone;
  logic       gameOver;
  logic       gameWon;

  logic [15:0] obs;
  int n_checks = 0;
  int n_fail   = 0;

  assign obs = {startTime, timerEnable, timerRst, roundNum, livesLeft, roundDone, gameOver, gameWon};

  round_timer_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pause       (pause),
    .hit         (hit),
    .timeout     (timeout),
    .startTime   (startTime),
    .timerEnable (timerEnable),
    .timerRst    (timerRst),
    .roundNum    (roundNum),
    .livesLeft   (livesLeft),
    .roundDone   (roundDone),
    .gameOver    (gameOver),
    .gameWon     (gameWon)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp = {4'd9, 1'b0, 1'b1, 4'd0, 3'd3, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs, exp);
    end
    tick();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL idle_hold: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_start();
    logic [15:0] exp;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp = {4'd9, 1'b0, 1'b1, 4'd0, 3'd3, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL start_load: got %h expected %h", obs, exp);
    end
    tick();
    exp = {4'd9, 1'b1, 1'b0, 4'd0, 3'd3, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL start_run: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_timeouts();
    logic [3:0]  exp_seq [8] = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd2};
    logic [15:0] exp;
    for (int i = 0; i < 8; i++) begin
      timeout = 1'b1;
      tick();
      timeout = 1'b0;
      exp = {exp_seq[i], 1'b0, 1'b1, 4'(i + 1), 3'd3, 1'b1, 1'b0, 1'b0};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL timeout_load_%0d: got %h expected %h", i + 1, obs, exp);
      end
      tick();
      exp = {exp_seq[i], 1'b1, 1'b0, 4'(i + 1), 3'd3, 1'b0, 1'b0, 1'b0};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL timeout_run_%0d: got %h expected %h", i + 1, obs, exp);
      end
    end
  endtask

  task automatic test_win();
    logic [15:0] exp;
    timeout = 1'b1;
    tick();
    timeout = 1'b0;
    exp = {4'd2, 1'b0, 1'b1, 4'd9, 3'd3, 1'b1, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL round9_load: got %h expected %h", obs, exp);
    end
    tick();
    timeout = 1'b1;
    tick();
    timeout = 1'b0;
    exp = {4'd2, 1'b0, 1'b1, 4'd10, 3'd3, 1'b1, 1'b1, 1'b1};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL win_entry: got %h expected %h", obs, exp);
    end
    tick();
    exp = {4'd2, 1'b0, 1'b1, 4'd10, 3'd3, 1'b0, 1'b1, 1'b1};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL win_hold: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_game_over_restart();
    logic [15:0] exp;
    hit = 1'b1;
    timeout = 1'b1;
    tick();
    hit = 1'b0;
    timeout = 1'b0;
    exp = {4'd2, 1'b0, 1'b1, 4'd10, 3'd3, 1'b0, 1'b1, 1'b1};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL game_over_ignores_hit: got %h expected %h", obs, exp);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    exp = {4'd9, 1'b0, 1'b1, 4'd0, 3'd3, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL restart_load: got %h expected %h", obs, exp);
    end
    tick();
    exp = {4'd9, 1'b1, 1'b0, 4'd0, 3'd3, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL restart_run: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_hits();
    logic [15:0] exp;
    timeout = 1'b1;
    tick();
    timeout = 1'b0;
    tick();
    exp = {4'd8, 1'b1, 1'b0, 4'd1, 3'd3, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL hits_setup: got %h expected %h", obs, exp);
    end
    hit = 1'b1;
    tick();
    hit = 1'b0;
    exp = {4'd8, 1'b0, 1'b1, 4'd1, 3'd2, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL hit1_load: got %h expected %h", obs, exp);
    end
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp = {4'd8, 1'b1, 1'b0, 4'd1, 3'd2, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL run_ignores_start: got %h expected %h", obs, exp);
    end
    hit = 1'b1;
    timeout = 1'b1;
    tick();
    hit = 1'b0;
    timeout = 1'b0;
    exp = {4'd8, 1'b0, 1'b1, 4'd1, 3'd1, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL hit_with_timeout: got %h expected %h", obs, exp);
    end
    tick();
    hit = 1'b1;
    tick();
    hit = 1'b0;
    exp = {4'd8, 1'b0, 1'b1, 4'd1, 3'd0, 1'b0, 1'b1, 1'b0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL hit3_loss: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_mid_run_reset();
    logic [15:0] exp;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp = {4'd9, 1'b0, 1'b1, 4'd0, 3'd3, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL loss_restart_load: got %h expected %h", obs, exp);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      timeout = 1'b1;
      tick();
      timeout = 1'b0;
      tick();
    end
    exp = {4'd5, 1'b1, 1'b0, 4'd4, 3'd3, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL round4_run: got %h expected %h", obs, exp);
    end
    rst = 1'b1;
    hit = 1'b1;
    tick();
    rst = 1'b0;
    hit = 1'b0;
    exp = {4'd9, 1'b0, 1'b1, 4'd0, 3'd3, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL mid_run_reset: got %h expected %h", obs, exp);
    end
    timeout = 1'b1;
    tick();
    timeout = 1'b0;
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL idle_ignores_timeout: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_pause();
    logic [15:0] exp;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    pause = 1'b1;
    tick();
`ifdef ROUND_TIMER_PAUSE_EN
    exp = {4'd9, 1'b0, 1'b0, 4'd0, 3'd3, 1'b0, 1'b0, 1'b0};
`else
    exp = {4'd9, 1'b1, 1'b0, 4'd0, 3'd3, 1'b0, 1'b0, 1'b0};
`endif
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL pause_enter: got %h expected %h", obs, exp);
    end
    timeout = 1'b1;
    tick();
    timeout = 1'b0;
`ifdef ROUND_TIMER_PAUSE_EN
    exp = {4'd9, 1'b0, 1'b0, 4'd0, 3'd3, 1'b0, 1'b0, 1'b0};
`else
    exp = {4'd8, 1'b0, 1'b1, 4'd1, 3'd3, 1'b1, 1'b0, 1'b0};
`endif
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL pause_timeout: got %h expected %h", obs, exp);
    end
    pause = 1'b0;
    tick();
`ifdef ROUND_TIMER_PAUSE_EN
    exp = {4'd9, 1'b1, 1'b0, 4'd0, 3'd3, 1'b0, 1'b0, 1'b0};
`else
    exp = {4'd8, 1'b1, 1'b0, 4'd1, 3'd3, 1'b0, 1'b0, 1'b0};
`endif
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL pause_resume: got %h expected %h", obs, exp);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_timeouts();
    test_win();
    test_game_over_restart();
    test_hits();
    test_mid_run_reset();
    test_pause();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
